uart_tx_serializer: RTL

Parametrised UART transmit serializer: the successor to the fixed 8-bit parity-input PISO in the full-duplex UART IP. It supports a configurable data width, parity mode and stop-bit count, and computes parity internally. A one-entry holding buffer allows back-to-back frames with no idle gap. It runs on the baud clock (one bit per cycle) and feeds the `tx` line directly.

---
 rtl/uart_tx_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DATA_W data bits LSB first, optional parity, 1-2 stop bits,
// with a one-word holding buffer for gapless frames. Define UART_TX_BREAK_EN to add the brk input.
module uart_tx_serializer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              baud_clk,
    input  logic              rst,
`ifdef UART_TX_BREAK_EN
    input  logic              brk,
`endif
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_serializer: DATA_W must be in 5..9");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  buf_q;
    logic               buf_full_q;
    logic               par_q;
    logic               brk_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               stop_cnt_q;

    logic brk_req;
    logic load;
    logic final_stop;
    logic xfer;
    logic buf_full_d;
    logic brk_next;

`ifdef UART_TX_BREAK_EN
    assign brk_req = brk;
`else
    assign brk_req = 1'b0;
`endif

    function automatic logic calc_par(input logic [DATA_W-1:0] d);
        return (PARITY_MODE == 2) ? ~^d : ^d;
    endfunction

    // Buffer hands over to the shifter when idle or on the last stop bit, giving zero-gap frames.
    always_comb begin
        load       = en && ready;
        final_stop = (state_q == StStop) && (stop_cnt_q == LAST_STOP);
        xfer       = buf_full_q && ((state_q == StIdle) || final_stop);
        buf_full_d = load || (buf_full_q && !xfer);
        brk_next   = brk_req && !buf_full_d;
    end

    assign ready = !buf_full_q && !brk_q;

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            par_q      <= 1'b0;
            brk_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= final_stop;
            buf_full_q <= buf_full_d;
            if (load) begin
                buf_q <= data_in;
            end
            if (xfer) begin
                state_q <= StStart;
                shift_q <= buf_q;
                par_q   <= calc_par(buf_q);
                brk_q   <= 1'b0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        brk_q <= brk_next;
                        tx    <= !brk_next;
                    end
                    StStart: begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                        tx        <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                    StData: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PARITY_MODE != 0) begin
                                state_q <= StParity;
                                tx      <= par_q;
                            end else begin
                                state_q    <= StStop;
                                stop_cnt_q <= 1'b0;
                                tx         <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            tx        <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    StParity: begin
                        state_q    <= StStop;
                        stop_cnt_q <= 1'b0;
                        tx         <= 1'b1;
                    end
                    StStop: begin
                        if (final_stop) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            brk_q   <= brk_next;
                            tx      <= !brk_next;
                        end else begin
                            stop_cnt_q <= ~stop_cnt_q;
                            tx         <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        tx      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
